// File: rtl/pcecd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcecd_pkg
// Description : Shared types and constants for the PC Engine CD SCSI target:
//               phase states, bus phase encodings, status/message bytes and
//               CDB length decode.
// Revision    : 1.0 - initial release
// ============================================================================
package pcecd_pkg;

    typedef enum logic [2:0] {
        ST_BUS_FREE = 3'd0,
        ST_COMMAND  = 3'd1,
        ST_EXEC     = 3'd2,
        ST_DATA_IN  = 3'd3,
        ST_STATUS   = 3'd4,
        ST_MSG_IN   = 3'd5,
        ST_MSG_WAIT = 3'd6
    } state_t;

    // Target phase signals packed as {bsy, msg, cd, io}
    localparam logic [3:0] PH_BUS_FREE = 4'b0000;
    localparam logic [3:0] PH_COMMAND  = 4'b1010;
    localparam logic [3:0] PH_DATA_IN  = 4'b1001;
    localparam logic [3:0] PH_STATUS   = 4'b1011;
    localparam logic [3:0] PH_MESSAGE  = 4'b1111;

    localparam logic [7:0] STATUS_GOOD      = 8'h00;
    localparam logic [7:0] STATUS_CHECK     = 8'h02;
    localparam logic [7:0] MSG_CMD_COMPLETE = 8'h00;

    // Group code in opcode bits [7:5] selects the CDB size
    function automatic logic [3:0] cdb_len(input logic [7:0] opcode);
        case (opcode[7:5])
            3'd1, 3'd2, 3'd6, 3'd7: return 4'd10;
            default:                return 4'd6;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcecd_drive_if.sv
`default_nettype none
// ============================================================================
// Module      : pcecd_drive_if
// Description : Initiator bus and command-executor signals of the CD drive.
//               slave = drive side, master = register block / executor side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pcecd_drive_if #(
    parameter int CMD_MAX = 10
);
    logic                   sel_i;
    logic                   ack_i;
    logic                   rst_i;
    logic [7:0]             db_i;
    logic                   bsy;
    logic                   req;
    logic                   msg;
    logic                   cd;
    logic                   io;
    logic [7:0]             db_o;
    logic                   cmd_valid;
    logic [8*CMD_MAX-1:0]   cmd_bytes;
    logic                   dat_valid;
    logic [7:0]             dat_byte;
    logic                   dat_ready;
    logic                   done_valid;
    logic [7:0]             done_status;
    logic                   irq_ready;
    logic                   irq_done;

    modport slave (
        input  sel_i, ack_i, rst_i, db_i, dat_valid, dat_byte, done_valid, done_status,
        output bsy, req, msg, cd, io, db_o, cmd_valid, cmd_bytes, dat_ready, irq_ready, irq_done
    );

    modport master (
        output sel_i, ack_i, rst_i, db_i, dat_valid, dat_byte, done_valid, done_status,
        input  bsy, req, msg, cd, io, db_o, cmd_valid, cmd_bytes, dat_ready, irq_ready, irq_done
    );
endinterface
`default_nettype wire

// File: rtl/pcecd_reqack.sv
`default_nettype none
// ============================================================================
// Module      : pcecd_reqack
// Description : One REQ/ACK byte handshake with a programmable REQ delay,
//               shared by command, data, status and message phases.
// Revision    : 1.0 - initial release
// ============================================================================
module pcecd_reqack #(
    parameter int REQ_DELAY = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clear,
    input  wire logic i_arm,
    input  wire logic i_auto_req,
    input  wire logic i_load,
    input  wire logic i_ack,
    output logic      o_req,
    output logic      o_launch_ok,
    output logic      o_strobe,
    output logic      o_done,
    output logic      o_busy
);

    localparam logic [3:0] c_req_delay = 4'(REQ_DELAY);

    logic [3:0] r_delay;
    logic       r_active;
    logic       r_req;
    logic       r_acked;
    logic       w_elapsed;
    logic       w_raise;

    // Counter hits zero on this edge, so REQ lands exactly REQ_DELAY cycles after arming
    assign w_elapsed   = (r_delay <= 4'd1);
    assign o_launch_ok = r_active && !r_req && !r_acked && w_elapsed && !i_ack;
    assign w_raise     = o_launch_ok && (i_auto_req || i_load);
    assign o_strobe    = r_req && i_ack;
    assign o_done      = r_acked && !i_ack;
    assign o_busy      = r_req || r_acked;
    assign o_req       = r_req;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_delay  <= 4'd0;
            r_active <= 1'b0;
            r_req    <= 1'b0;
            r_acked  <= 1'b0;
        end else if (i_clear) begin
            r_delay  <= 4'd0;
            r_active <= 1'b0;
            r_req    <= 1'b0;
            r_acked  <= 1'b0;
        end else begin
            if (i_arm) begin
                r_delay  <= c_req_delay;
                r_active <= 1'b1;
            end else if (r_delay != 4'd0) begin
                r_delay <= r_delay - 4'd1;
            end
            if (w_raise) begin
                r_req    <= 1'b1;
                r_active <= 1'b0;
            end
            if (o_strobe) begin
                r_req   <= 1'b0;
                r_acked <= 1'b1;
            end
            if (o_done) begin
                r_acked <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcecd_drive.sv
`default_nettype none
// ============================================================================
// Module      : pcecd_drive
// Description : SCSI target phase engine: collects CDBs, streams data-in
//               bytes, then sends status and command-complete message.
// Revision    : 1.0 - initial release
// ============================================================================
module pcecd_drive
    import pcecd_pkg::*;
#(
    parameter int CMD_MAX   = 10,
    parameter int REQ_DELAY = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    pcecd_drive_if.slave  bus
);

    state_t               r_state;
    logic [3:0]           r_phase;
    logic [3:0]           r_index;
    logic [8*CMD_MAX-1:0] r_buf;
    logic [7:0]           r_db_o;
    logic                 r_cmd_valid;
    logic                 r_irq_ready;
    logic                 r_irq_done;
    logic                 r_first_sent;

    logic w_req;
    logic w_launch_ok;
    logic w_strobe;
    logic w_done;
    logic w_busy;
    logic w_arm;
    logic w_auto_req;
    logic w_cmd_last;
    logic w_xfer;
    logic w_din_done;

    assign w_cmd_last = (r_index + 4'd1) == cdb_len(r_buf[7:0]);
    assign w_auto_req = (r_state == ST_COMMAND) || (r_state == ST_STATUS) || (r_state == ST_MSG_IN);
    assign w_xfer     = (r_state == ST_DATA_IN) && w_launch_ok && bus.dat_valid
                        && !bus.done_valid && !bus.rst_i;
    assign w_din_done = (r_state == ST_DATA_IN) && bus.done_valid && !w_busy && !bus.ack_i;

    // Every phase entry and every completed byte that is followed by another restarts the delay
    assign w_arm = ((r_state == ST_BUS_FREE) && bus.sel_i)
                || ((r_state == ST_COMMAND) && w_done && !w_cmd_last)
                || ((r_state == ST_EXEC) && (bus.done_valid || bus.dat_valid))
                || ((r_state == ST_DATA_IN) && (w_din_done || w_done))
                || ((r_state == ST_STATUS) && w_done);

    pcecd_reqack #(
        .REQ_DELAY (REQ_DELAY)
    ) u_reqack (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (bus.rst_i),
        .i_arm       (w_arm),
        .i_auto_req  (w_auto_req),
        .i_load      (w_xfer),
        .i_ack       (bus.ack_i),
        .o_req       (w_req),
        .o_launch_ok (w_launch_ok),
        .o_strobe    (w_strobe),
        .o_done      (w_done),
        .o_busy      (w_busy)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_BUS_FREE;
            r_phase      <= PH_BUS_FREE;
            r_index      <= 4'd0;
            r_buf        <= '0;
            r_db_o       <= 8'h00;
            r_cmd_valid  <= 1'b0;
            r_irq_ready  <= 1'b0;
            r_irq_done   <= 1'b0;
            r_first_sent <= 1'b0;
        end else if (bus.rst_i) begin
            r_state      <= ST_BUS_FREE;
            r_phase      <= PH_BUS_FREE;
            r_index      <= 4'd0;
            r_buf        <= '0;
            r_db_o       <= 8'h00;
            r_cmd_valid  <= 1'b0;
            r_irq_ready  <= 1'b0;
            r_irq_done   <= 1'b0;
            r_first_sent <= 1'b0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_irq_ready <= 1'b0;
            r_irq_done  <= 1'b0;
            case (r_state)
                ST_BUS_FREE: begin
                    if (bus.sel_i) begin
                        r_state      <= ST_COMMAND;
                        r_phase      <= PH_COMMAND;
                        r_index      <= 4'd0;
                        r_buf        <= '0;
                        r_first_sent <= 1'b0;
                    end
                end
                ST_COMMAND: begin
                    if (w_strobe) begin
                        for (int i = 0; i < CMD_MAX; i++) begin
                            if (r_index == i[3:0]) begin
                                r_buf[i*8 +: 8] <= bus.db_i;
                            end
                        end
                    end
                    if (w_done) begin
                        r_index <= r_index + 4'd1;
                        if (w_cmd_last) begin
                            r_cmd_valid <= 1'b1;
                            r_state     <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (bus.done_valid) begin
                        r_state    <= ST_STATUS;
                        r_phase    <= PH_STATUS;
                        r_db_o     <= bus.done_status;
                        r_irq_done <= 1'b1;
                    end else if (bus.dat_valid) begin
                        r_state <= ST_DATA_IN;
                        r_phase <= PH_DATA_IN;
                    end
                end
                ST_DATA_IN: begin
                    if (w_din_done) begin
                        r_state    <= ST_STATUS;
                        r_phase    <= PH_STATUS;
                        r_db_o     <= bus.done_status;
                        r_irq_done <= 1'b1;
                    end else if (w_xfer) begin
                        r_db_o <= bus.dat_byte;
                        if (!r_first_sent) begin
                            r_irq_ready  <= 1'b1;
                            r_first_sent <= 1'b1;
                        end
                    end
                end
                ST_STATUS: begin
                    if (w_done) begin
                        r_state <= ST_MSG_IN;
                        r_phase <= PH_MESSAGE;
                        r_db_o  <= MSG_CMD_COMPLETE;
                    end
                end
                ST_MSG_IN: begin
                    if (w_strobe) begin
                        r_state <= ST_MSG_WAIT;
                    end
                end
                ST_MSG_WAIT: begin
                    if (w_done) begin
                        r_state <= ST_BUS_FREE;
                        r_phase <= PH_BUS_FREE;
                        r_db_o  <= 8'h00;
                        r_buf   <= '0;
                    end
                end
                default: begin
                    r_state <= ST_BUS_FREE;
                    r_phase <= PH_BUS_FREE;
                end
            endcase
        end
    end

    assign bus.bsy       = r_phase[3];
    assign bus.msg       = r_phase[2];
    assign bus.cd        = r_phase[1];
    assign bus.io        = r_phase[0];
    assign bus.req       = w_req;
    assign bus.db_o      = r_db_o;
    assign bus.cmd_valid = r_cmd_valid;
    assign bus.cmd_bytes = r_buf;
    assign bus.dat_ready = w_xfer;
    assign bus.irq_ready = r_irq_ready;
    assign bus.irq_done  = r_irq_done;

endmodule
`default_nettype wire

// File: doc/pcecd_drive.md
Name: pcecd_drive

Overview:
- SCSI target-side phase engine for the PC Engine CD interface; sits directly downstream of the CPU register block, which drives the initiator signals (SEL/ACK/RST, data bus) and reads back the target signals (BSY/REQ/MSG/CD/IO, data bus, IRQ events).
- Collects command bytes with the REQ/ACK handshake and hands complete commands to a command executor.
- Streams executor data bytes to the initiator, then sends status and message bytes and returns to bus free.

Parameters:
- CMD_MAX, default 10: command buffer depth in bytes. 6-byte and 10-byte CDBs are supported.
- REQ_DELAY, default 4: idle cycles between a phase entry or a byte being loaded and REQ rising. Range 0..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-low
- sel_i  in  1  initiator SEL
- ack_i  in  1  initiator ACK
- rst_i  in  1  initiator bus RST; synchronous abort
- db_i  in  8  initiator data bus (command bytes)
- bsy  out  1  target BSY
- req  out  1  target REQ
- msg  out  1  target MSG
- cd  out  1  target C/D
- io  out  1  target I/O
- db_o  out  8  target data bus (data/status/message bytes)
- cmd_valid  out  1  one-cycle pulse: command complete
- cmd_bytes  out  8*CMD_MAX  CDB; byte 0 in bits [7:0]; unused bytes are zero
- dat_valid  in  1  executor data byte available
- dat_byte  in  8  executor data byte
- dat_ready  out  1  data byte accepted; valid and ready high in the same cycle is a transfer
- done_valid  in  1  executor finished; sampled only in EXEC or DATA_IN
- done_status  in  8  SCSI status byte (0x00 good, 0x02 check condition)
- irq_ready  out  1  one-cycle pulse on the first DATA_IN byte of a command
- irq_done  out  1  one-cycle pulse on STATUS entry

Behaviour:
- States: BUS_FREE, COMMAND, EXEC, DATA_IN, STATUS, MSG_IN, MSG_WAIT.
- Target signal encoding per state as {bsy,msg,cd,io}:
  - BUS_FREE 0000
  - COMMAND 1010
  - EXEC 1010, REQ held low
  - DATA_IN 1001
  - STATUS 1011
  - MSG_IN / MSG_WAIT 1111
- Reset (async, active-low): state BUS_FREE; all outputs 0; buffer cleared; delay counter 0.
- rst_i high: next clock forces BUS_FREE from any state, clears the buffer and byte index, and drops REQ. No cmd_valid or irq pulse is produced. rst_i has priority over all other events.
- BUS_FREE: sel_i high -> COMMAND, byte index 0, delay counter loaded with REQ_DELAY.
- REQ delay: REQ rises when the delay counter reaches 0 and ack_i is low.
- COMMAND handshake:
  - req high and ack_i high in the same cycle: latch db_i into buffer[index]; REQ low the next cycle.
  - Then wait for ack_i low, index+1, reload the delay counter.
- CDB length is decided from byte 0 bits [7:5]:
  - 0 -> 6 bytes
  - 1, 2, 6, 7 -> 10 bytes
  - otherwise -> 6 bytes
- When index reaches the CDB length and ack_i is low: cmd_valid pulses for one cycle with cmd_bytes valid that cycle; go to EXEC.
- EXEC: wait for the executor.
  - done_valid wins over dat_valid when both are high.
  - done_valid -> STATUS.
  - dat_valid -> DATA_IN.
- DATA_IN:
  - With REQ low, the delay elapsed and ack_i low: dat_ready=1 for one cycle (transfer), dat_byte loads into db_o, REQ rises the next cycle.
  - req and ack_i high: REQ low. ack_i low again: next byte.
  - done_valid with no byte in flight (REQ low, ack_i low) -> STATUS.
- STATUS: db_o=done_status (latched on done), REQ after delay, irq_done pulses on entry. ACK rise -> REQ low; ACK fall -> MSG_IN.
- MSG_IN: db_o=0x00 (command complete), REQ after delay. ACK rise -> REQ low -> MSG_WAIT. ACK fall -> BUS_FREE.
- ack_i high while REQ is low and no byte is pending: ignored, no latch.
- sel_i outside BUS_FREE: ignored.
- A CDB longer than CMD_MAX cannot occur because the decoded length is at most 10.
- Index width is 4 bits. The delay counter is 4 bits and saturates at 0.

Decomposition:
- Package pcecd_pkg holds:
  - the state enum
  - phase signal encodings
  - status constants (STATUS_GOOD=0x00, STATUS_CHECK=0x02)
  - MSG_CMD_COMPLETE=0x00
  - the CDB-length function
- One natural sub-module, pcecd_reqack: a REQ/ACK byte handshake with the delay counter. It is reused for command, data, status and message bytes.

Test Plan:
- sel_i, then 6 bytes 0x00 0 0 0 0 0 via REQ/ACK -> one cmd_valid pulse, cmd_bytes[47:0]=0, upper bytes 0. Then done_valid with status 0x00 -> STATUS with db_o=0x00 and irq_done pulse, MSG_IN with db_o=0x00, then BUS_FREE with all outputs 0.
- 10-byte CDB starting 0xD8 -> cmd_valid only after the 10th ACK falls; cmd_bytes[7:0]=0xD8.
- READ flow: the executor supplies 0x11, 0x22, 0x33, then done 0x00 -> db_o shows the three bytes in order, irq_ready pulses once, dat_ready pulses 3 times, then status 0x00 and message 0x00.
- Check condition: done_status=0x02 -> the status byte on db_o is 0x02 with {bsy,msg,cd,io}=1011.
- rst_i asserted during DATA_IN after 1 of 3 bytes -> BUS_FREE the next cycle, req=0, no irq_done. A new sel_i starts COMMAND at index 0.
- Async reset (reset low) mid-COMMAND, off clock edge -> outputs 0 immediately. After release, sel_i restarts cleanly; REQ rises REQ_DELAY cycles after COMMAND entry.
